fb_block_writer: RTL and testbench
==================================

# fb_block_writer

Parametrised frame-buffer write packer between the pixel-producing pipeline (rasterizer/shader) and the DRAM write port (write_ready / write_request / write_address / write_data). It walks the frame in raster order, publishes the coordinate of the next expected pixel, and accepts pixels with valid/ready backpressure. It packs BLOCK_PIXELS pixels into one DRAM block and keeps a 2-deep block queue so packing continues while a block waits for DRAM. It also has a hardware clear mode that fills a whole frame with a constant colour.

## Interface
Parameters:
- PIXEL_BITS, 16, width of one stored pixel
- BLOCK_PIXELS, 256, pixels per DRAM block (power of 2); wr_data is PIXEL_BITS*BLOCK_PIXELS bits
- FRAME_WIDTH, 1024, pixels per line
- FRAME_HEIGHT, 768, lines per frame; FRAME_WIDTH*FRAME_HEIGHT must be a multiple of BLOCK_PIXELS
- ADDR_BITS, 27, DRAM address width, in pixel units
- REQ_HOLDOFF, 4, cycles wr_ready is ignored after each wr_request

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel offered
- pix_data  in  PIXEL_BITS  pixel value
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- x_out  out  $clog2(FRAME_WIDTH)  column of the next pixel expected
- y_out  out  $clog2(FRAME_HEIGHT)  line of the next pixel expected
- clear_req  in  1  request a full-frame clear (level or pulse)
- clear_color  in  PIXEL_BITS  clear value, sampled when the clear starts
- wr_ready  in  1  DRAM able to take a write
- wr_request  out  1  one-cycle write strobe
- wr_addr  out  ADDR_BITS  pixel index of the block's first pixel
- wr_data  out  PIXEL_BITS*BLOCK_PIXELS  packed block
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is packed
- clearing  out  1  high while in S_CLEAR
- clear_pending  out  1  clear request latched, waiting for the frame boundary

## Operation
- States: S_STREAM (pixels come from pix_*) and S_CLEAR (pixels are generated internally as latched clear_color).
- Pixel pointer (x, y) and in-block index k: on every accepted or generated pixel, k increments. x increments and wraps to 0 at FRAME_WIDTH-1, and y increments on that wrap. y wraps to 0 at FRAME_HEIGHT-1, and frame_done pulses in that cycle.
- Packing: the pixel with in-block index k goes to bits [k*PIXEL_BITS +: PIXEL_BITS]. Block address = FRAME_WIDTH*y + x of pixel k=0, computed at ADDR_BITS width.
- When pixel k=BLOCK_PIXELS-1 is taken, the completed block, with that pixel included, is pushed into the queue in the same cycle, and k returns to 0.
- pix_ready = !rst && state==S_STREAM && !(k==BLOCK_PIXELS-1 && queue_count==2). pix_ready depends on registered state only, never on pix_valid or wr_ready.
- S_CLEAR generates one pixel per cycle under the same queue-full condition.
- Issue: the queue is non-empty, wr_ready=1 and the holdoff counter is 0. On the next edge: wr_request<=1, wr_addr/wr_data<=head, head popped, holdoff<=REQ_HOLDOFF. Next cycle wr_request<=0.
- wr_addr/wr_data hold their value until the next issue.
- Push and pop in the same cycle leave queue_count unchanged. Order is strictly FIFO.
- Clear:
  - clear_req=1 sets clear_pending.
  - At a frame boundary (x=0, y=0, k=0), with clear_pending set, enter S_CLEAR: latch clear_color, clear clear_pending.
  - At end of frame (frame_done), return to S_STREAM.
  - clear_req during S_CLEAR sets clear_pending for the following frame.
- Reset mid-operation drops the partial block and all queued blocks. No wr_request is issued for them.

## Timing
- Reset values: pix_ready 0, x_out 0, y_out 0, wr_request 0, wr_addr 0, wr_data 0, frame_done 0, clearing 0, clear_pending 0, queue empty, k 0, holdoff 0, state S_STREAM. pix_ready is 1 in the first cycle after rst falls.
- Throughput: 1 pixel/cycle while the queue has room.
- Latency: last-pixel handshake in cycle N, queue_count 1 in N+1, wr_request=1 in N+2 if wr_ready=1 in N+1 and holdoff is 0.
- Minimum spacing of wr_request rising edges is REQ_HOLDOFF+1 cycles.
- frame_done is high in the cycle after the handshake of pixel (FRAME_WIDTH-1, FRAME_HEIGHT-1).
- x_out/y_out update the cycle after each accepted pixel.

## Test plan
Bench parameters: PIXEL_BITS=4, BLOCK_PIXELS=4, FRAME_WIDTH=8, FRAME_HEIGHT=2, REQ_HOLDOFF=2.
- Stream pixels 0x1..0x4, wr_ready=1 -> one wr_request with wr_addr=0 and wr_data=16'h4321. x_out steps 0..3.
- Stream a full 16-pixel frame, wr_ready=1 -> four requests with addresses 0, 4, 8, 12. frame_done pulses once. x/y return to 0,0.
- Hold wr_ready=0 and stream -> pix_ready drops at k=3 after 2 queued blocks (11 pixels accepted). Raise wr_ready -> blocks 0 and 4 issue in order, at least 3 cycles apart, and streaming resumes.
- Assert clear_req after pixel 5 with clear_color=0xA -> clear_pending=1 until the frame ends. The next frame issues four blocks of 16'hAAAA with pix_ready=0 and clearing=1, then frame_done, then S_STREAM.
- Assert rst with 1 block queued and 2 pixels partially packed -> no wr_request afterwards, all outputs at reset values, and the next stream starts at wr_addr=0.

Source files
------------

// File: rtl/fb_block_writer.sv
// fb_block_writer: packs a raster-order pixel stream (or an internally
// generated clear colour) into BLOCK_PIXELS-wide DRAM blocks. The blocks go
// through a 2-deep FIFO ahead of a held-off write strobe.
module fb_block_writer #(
  parameter int PIXEL_BITS   = 16,
  parameter int BLOCK_PIXELS = 256,
  parameter int FRAME_WIDTH  = 1024,
  parameter int FRAME_HEIGHT = 768,
  parameter int ADDR_BITS    = 27,
  parameter int REQ_HOLDOFF  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pix_valid,
  input  logic [PIXEL_BITS-1:0]              pix_data,
  output logic                               pix_ready,
  output logic [$clog2(FRAME_WIDTH)-1:0]     x_out,
  output logic [$clog2(FRAME_HEIGHT)-1:0]    y_out,
  input  logic                               clear_req,
  input  logic [PIXEL_BITS-1:0]              clear_color,
  input  logic                               wr_ready,
  output logic                               wr_request,
  output logic [ADDR_BITS-1:0]               wr_addr,
  output logic [PIXEL_BITS*BLOCK_PIXELS-1:0] wr_data,
  output logic                               frame_done,
  output logic                               clearing,
  output logic                               clear_pending
);

  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);
  localparam int KW = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam int HW = (REQ_HOLDOFF > 0) ? $clog2(REQ_HOLDOFF + 1) : 1;
  localparam int DW = PIXEL_BITS * BLOCK_PIXELS;

  typedef enum logic {S_STREAM = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                state, state_nx;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [KW-1:0]         k;
  logic [PIXEL_BITS-1:0] clear_val;
  logic [DW-1:0]         pack;
  logic [ADDR_BITS-1:0]  base_addr;
  logic [ADDR_BITS-1:0]  q_addr [2];
  logic [DW-1:0]         q_data [2];
  logic [1:0]            q_count;
  logic [HW-1:0]         holdoff;

  logic                  at_origin, last_k, last_x, last_y, stall;
  logic                  enter_clear, take, push, issue, frame_end;
  logic [PIXEL_BITS-1:0] pixel;
  logic [ADDR_BITS-1:0]  cur_addr, blk_addr;
  logic [DW-1:0]         blk_data;

  assign x_out    = x;
  assign y_out    = y;
  assign clearing = (state == S_CLEAR);

  // Handshake, pixel source selection and assembly of the block being packed.
  always_comb begin
    at_origin   = (x == '0) && (y == '0) && (k == '0);
    last_k      = (k == KW'(BLOCK_PIXELS - 1));
    last_x      = (x == XW'(FRAME_WIDTH - 1));
    last_y      = (y == YW'(FRAME_HEIGHT - 1));
    stall       = last_k && (q_count == 2'd2);
    enter_clear = (state == S_STREAM) && clear_pending && at_origin;
    // The frame-boundary cycle that switches to clear mode takes no stream
    // pixel, so a cleared frame never contains a stray streamed pixel 0.
    pix_ready   = !rst && (state == S_STREAM) && !stall && !enter_clear;
    take        = (state == S_STREAM) ? (pix_valid && pix_ready) : !stall;
    pixel       = (state == S_CLEAR) ? clear_val : pix_data;
    frame_end   = take && last_x && last_y;
    push        = take && last_k;
    issue       = (q_count != 2'd0) && wr_ready && (holdoff == '0);
    cur_addr    = ADDR_BITS'(FRAME_WIDTH) * ADDR_BITS'(y) + ADDR_BITS'(x);
    blk_addr    = (k == '0) ? cur_addr : base_addr;
    blk_data    = pack;
    blk_data[k*PIXEL_BITS +: PIXEL_BITS] = pixel;
  end

  // Next-state logic: clear starts at a frame boundary, ends with the frame.
  always_comb begin
    state_nx = state;
    case (state)
      S_STREAM: if (enter_clear) state_nx = S_CLEAR;
      S_CLEAR:  if (frame_end)   state_nx = S_STREAM;
      default:  state_nx = S_STREAM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_STREAM;
    else     state <= state_nx;
  end

  // Raster pointer, in-block index and packing buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      k         <= '0;
      pack      <= '0;
      base_addr <= '0;
    end else if (take) begin
      k    <= last_k ? '0 : k + KW'(1);
      x    <= last_x ? '0 : x + XW'(1);
      pack <= blk_data;
      if (last_x) y <= last_y ? '0 : y + YW'(1);
      if (k == '0) base_addr <= cur_addr;
    end
  end

  // Clear request latch, clear colour capture and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_pending <= 1'b0;
      clear_val     <= '0;
      frame_done    <= 1'b0;
    end else begin
      clear_pending <= (clear_pending && !enter_clear) || clear_req;
      if (enter_clear) clear_val <= clear_color;
      frame_done    <= frame_end;
    end
  end

  // Two-entry block FIFO; slot 0 is always the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_count <= 2'd0;
      q_addr  <= '{default: '0};
      q_data  <= '{default: '0};
    end else begin
      if (issue) begin
        q_addr[0] <= q_addr[1];
        q_data[0] <= q_data[1];
      end
      // With a simultaneous pop the new block lands one slot lower.
      if (push) begin
        if (q_count == 2'd0 || (q_count == 2'd1 && issue)) begin
          q_addr[0] <= blk_addr;
          q_data[0] <= blk_data;
        end else begin
          q_addr[1] <= blk_addr;
          q_data[1] <= blk_data;
        end
      end
      q_count <= q_count + 2'(push) - 2'(issue);
    end
  end

  // DRAM write strobe with post-request holdoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_request <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      holdoff    <= '0;
    end else begin
      wr_request <= issue;
      if (issue) begin
        wr_addr <= q_addr[0];
        wr_data <= q_data[0];
        holdoff <= HW'(REQ_HOLDOFF);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fb_block_writer.sv
// Directed bench for fb_block_writer with a tiny 8x2 frame and 4-pixel blocks.
module tb_fb_block_writer;

  localparam int PB = 4;
  localparam int BP = 4;
  localparam int FW = 8;
  localparam int FH = 2;
  localparam int AB = 27;
  localparam int HO = 2;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic [PB-1:0] pix_data;
  logic          pix_ready;
  logic [2:0]    x_out;
  logic [0:0]    y_out;
  logic          clear_req;
  logic [PB-1:0] clear_color;
  logic          wr_ready;
  logic          wr_request;
  logic [AB-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          clearing;
  logic          clear_pending;

  fb_block_writer #(
    .PIXEL_BITS  (PB),
    .BLOCK_PIXELS(BP),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .ADDR_BITS   (AB),
    .REQ_HOLDOFF (HO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .x_out        (x_out),
    .y_out        (y_out),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .wr_ready     (wr_ready),
    .wr_request   (wr_request),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_done   (frame_done),
    .clearing     (clearing),
    .clear_pending(clear_pending)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_count = 0;

  logic [AB-1:0] req_addr[$];
  logic [15:0]   req_data[$];
  int            req_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every write strobe and frame_done pulse away from the clock edge.
  always @(negedge clk) begin
    if (wr_request) begin
      req_addr.push_back(wr_addr);
      req_data.push_back(wr_data);
      req_cyc.push_back(cyc);
    end
    if (frame_done) fd_count++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one pixel starting at a negedge; returns at the negedge after the handshake.
  task automatic push_pix(input logic [PB-1:0] d);
    int unsigned t;
    t = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    while (!pix_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pix_ready_wait", pix_ready, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_reqs(input string tag, input int n);
    int unsigned t;
    t = 0;
    while (req_addr.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk(tag, req_addr.size(), n);
  endtask

  // Check four consecutive requests at 0,4,8,12 against packed data words.
  task automatic check_frame_reqs(input string tag, input int first, input logic [63:0] datas);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, req_addr[first+i], 64'(i * 4));
      chk({tag, "_data"}, req_data[first+i], datas[i*16 +: 16]);
    end
  endtask

  initial begin
    int last_hs;
    int fd_base;
    int n_clear;
    int rdy_during_clear;

    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = '0;
    clear_req   = 1'b0;
    clear_color = '0;
    wr_ready    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_x", x_out, 3'd0);
    chk("rst_y", y_out, 1'b0);
    chk("rst_wr_request", wr_request, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, 16'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_clearing", clearing, 1'b0);
    chk("rst_clear_pending", clear_pending, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pix_ready", pix_ready, 1'b1);

    // Single block 1..4 with x_out stepping
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_x_step", x_out, 3'(i));
      push_pix(4'(i + 1));
    end
    last_hs = cyc;
    chk("t1_x_after", x_out, 3'd4);
    wait_reqs("t1_req_count", 1);
    chk("t1_addr", req_addr[0], 64'd0);
    chk("t1_data", req_data[0], 16'h4321);
    chk("t1_latency", 64'(req_cyc[0]), 64'(last_hs + 1));
    chk("t1_wr_data_held", wr_data, 16'h4321);

    // Complete the frame (values 5..F,0)
    fd_base = fd_count;
    for (int i = 4; i < 16; i++) push_pix(4'(i + 1));
    chk("t2a_frame_done", frame_done, 1'b1);
    wait_reqs("t2a_req_count", 4);
    check_frame_reqs("t2a", 0, 64'h0FED_CBA9_8765_4321);
    chk("t2a_fd_count", 64'(fd_count - fd_base), 64'd1);

    // Full 16-pixel frame, values 0..F
    req_addr.delete(); req_data.delete(); req_cyc.delete();
    fd_base = fd_count;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("t2b_x_last", x_out, 3'd7);
        chk("t2b_y_last", y_out, 1'b1);
      end
      push_pix(4'(i));
    end
    chk("t2b_frame_done", frame_done, 1'b1);
    wait_reqs("t2b_req_count", 4);
    check_frame_reqs("t2b", 0, 64'hFEDC_BA98_7654_3210);
    chk("t2b_fd_count", 64'(fd_count - fd_base), 64'd1);
    chk("t2b_x_wrap", x_out, 3'd0);
    chk("t2b_y_wrap", y_out, 1'b0);

    // Backpressure: wr_ready low, queue fills after 11 pixels
    req_addr.delete(); req_data.delete(); req_cyc.delete();
    wr_ready = 1'b0;
    for (int i = 0; i < 11; i++) push_pix(4'(i));
    pix_valid = 1'b1;
    pix_data  = 4'hB;
    repeat (2) @(negedge clk);
    chk("t3_stall_ready", pix_ready, 1'b0);
    chk("t3_stall_x", x_out, 3'd3);
    chk("t3_stall_y", y_out, 1'b1);
    chk("t3_no_req", req_addr.size(), 0);
    wr_ready = 1'b1;
    push_pix(4'hB);
    for (int i = 12; i < 16; i++) push_pix(4'(i));
    wait_reqs("t3_req_count", 4);
    check_frame_reqs("t3", 0, 64'hFEDC_BA98_7654_3210);
    chk("t3_spacing", 64'(req_cyc[1] - req_cyc[0]), 64'd3);

    // Clear request mid-frame, clear frame follows
    req_addr.delete(); req_data.delete(); req_cyc.delete();
    fd_base = fd_count;
    for (int i = 0; i < 6; i++) push_pix(4'(i));
    clear_color = 4'hA;
    clear_req   = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("t4_pending_set", clear_pending, 1'b1);
    chk("t4_not_clearing", clearing, 1'b0);
    for (int i = 6; i < 16; i++) push_pix(4'(i));
    chk("t4_pending_at_end", clear_pending, 1'b1);
    chk("t4_fd_stream", frame_done, 1'b1);
    @(negedge clk);
    chk("t4_clearing", clearing, 1'b1);
    chk("t4_pending_cleared", clear_pending, 1'b0);
    clear_color = 4'h5;
    n_clear = 0;
    rdy_during_clear = 0;
    while (clearing && n_clear < 40) begin
      n_clear++;
      if (pix_ready) rdy_during_clear++;
      @(negedge clk);
    end
    chk("t4_clear_cycles", 64'(n_clear), 64'd16);
    chk("t4_ready_in_clear", 64'(rdy_during_clear), 64'd0);
    chk("t4_fd_clear", frame_done, 1'b1);
    chk("t4_back_stream", pix_ready, 1'b1);
    chk("t4_x_end", x_out, 3'd0);
    chk("t4_y_end", y_out, 1'b0);
    wait_reqs("t4_req_count", 8);
    check_frame_reqs("t4s", 0, 64'hFEDC_BA98_7654_3210);
    check_frame_reqs("t4c", 4, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t4_fd_count", 64'(fd_count - fd_base), 64'd2);

    // Reset with one block queued and two pixels partially packed
    req_addr.delete(); req_data.delete(); req_cyc.delete();
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_pix(4'(i + 1));
    chk("t5_pre_no_req", req_addr.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_pix_ready", pix_ready, 1'b0);
    chk("t5_rst_x", x_out, 3'd0);
    chk("t5_rst_wr_addr", wr_addr, '0);
    chk("t5_rst_wr_data", wr_data, 16'h0);
    chk("t5_rst_clearing", clearing, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    wr_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_req_after_rst", req_addr.size(), 0);
    for (int i = 0; i < 4; i++) push_pix(4'(i + 1));
    wait_reqs("t5_req_count", 1);
    chk("t5_addr", req_addr[0], 64'd0);
    chk("t5_data", req_data[0], 16'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
